// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module : imem_loader_pkg
// Brief  : Shared state encoding and default parameters for the imem loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_e;

  localparam logic [7:0]  MAGIC_DEFAULT     = 8'hA5;
  localparam int          MAX_WORDS_DEFAULT = 4096;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h0000_0000;
  localparam int          INDEX_W           = 13;

endpackage

`default_nettype wire

// File: rtl/imem_loader_word_assembler.sv
// ============================================================================
// Module : word_assembler
// Brief  : Packs bytes MSB-first into 32-bit words; pulses word_valid_o the
//          cycle after the 4th byte of each word.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        last_byte_o
);

  logic [31:0] shift_q;
  logic [1:0]  cnt_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid_i && (cnt_q == 2'd3);
      if (clear_i) begin
        cnt_q <= '0;
      end else if (byte_valid_i) begin
        shift_q <= {shift_q[23:0], byte_i};
        cnt_q   <= cnt_q + 2'd1;
      end
    end
  end

  assign word_o       = shift_q;
  assign word_valid_o = valid_q;
  assign last_byte_o  = (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module : imem_loader
// Brief  : Boot loader writing the instruction RAM from a framed byte stream.
//          Optional trailing XOR checksum enabled by IMEM_LOADER_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          MAX_WORDS = MAX_WORDS_DEFAULT,
  parameter logic [7:0]  MAGIC     = MAGIC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic        start_i,
  output logic        mem_we_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        error_o
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e S_TAIL = S_CHECK;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  state_e               state_q, state_d;
  logic                 live_q;
  logic [15:0]          count_q;
  logic [INDEX_W-1:0]   index_q;
  logic                 w_accept, w_rearm, w_word_valid, w_last_byte, w_last_word;
  logic [15:0]          w_count;

  assign w_accept    = rx_valid_i && rx_ready_o;
  assign w_rearm     = start_i && ((state_q == S_DONE) || (state_q == S_ERROR));
  assign w_count     = {count_q[15:8], rx_data_i};
  assign w_last_word = ((16'(index_q) + 16'd1) == count_q);

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (w_rearm),
    .byte_valid_i (w_accept && (state_q == S_DATA)),
    .byte_i       (rx_data_i),
    .word_o       (mem_wdata_o),
    .word_valid_o (w_word_valid),
    .last_byte_o  (w_last_byte)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (w_rearm) begin
      csum_q <= '0;
    end else if (w_accept && (state_q == S_DATA)) begin
      csum_q <= csum_q ^ rx_data_i;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      count_q <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      // The index advances during the write cycle so the address stays stable.
      if (w_rearm) begin
        index_q <= '0;
      end else if (w_word_valid) begin
        index_q <= index_q + INDEX_W'(1);
      end
      if (w_accept && (state_q == S_HDR_HI)) count_q[15:8] <= rx_data_i;
      if (w_accept && (state_q == S_HDR_LO)) count_q[7:0]  <= rx_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (w_accept && (rx_data_i == MAGIC)) state_d = S_HDR_HI;
      S_HDR_HI: if (w_accept) state_d = S_HDR_LO;
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_count > MAX_N)         state_d = S_ERROR;
          else if (w_count == 16'd0)   state_d = S_TAIL;
          else                         state_d = S_DATA;
        end
      end
      S_DATA:   if (w_accept && w_last_byte && w_last_word) state_d = S_TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:  if (w_accept) state_d = (rx_data_i == csum_q) ? S_DONE : S_ERROR;
`endif
      S_DONE, S_ERROR: if (start_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_ready_o = 1'b0;
    done_o     = 1'b0;
    error_o    = 1'b0;
    cpu_hold_o = 1'b1;
    case (state_q)
      S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CHECK: rx_ready_o = live_q;
      S_DONE: begin
        done_o     = 1'b1;
        cpu_hold_o = 1'b0;
      end
      S_ERROR: error_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_we_o      = w_word_valid;
  assign mem_address_o = BASE_ADDR + {17'b0, index_q, 2'b00};

endmodule

`default_nettype wire
